// File: rtl/alu_exec_pkg.sv
// Shared op codes, ALUop encodings and FSM state encodings for the ALU execute stage.
package alu_exec_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLTU = 4'b0111;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SRA  = 4'b1001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1010;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_ITER = 2'd2;
    localparam state_t S_DONE = 2'd3;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU-control decode: {alu_op, funct3, funct7} -> {op, illegal}.
// Define ALU_MUL_EN to decode R-type funct7=0000001/funct3=000 as MUL.
module alu_op_decode
    import alu_exec_pkg::*;
(
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    output logic [OP_W-1:0] op_c_o,
    output logic            illegal_c_o
);

    always_comb begin
        op_c_o      = OP_ADD;
        illegal_c_o = 1'b0;
        case (alu_op_i)
            ALUOP_LDST: op_c_o = OP_ADD;
            ALUOP_BRANCH: begin
                case (funct3_i[2:1])
                    2'b00:   op_c_o = OP_SUB;
                    2'b10:   op_c_o = OP_SLT;
                    2'b11:   op_c_o = OP_SLTU;
                    default: illegal_c_o = 1'b1;
                endcase
            end
            ALUOP_RTYPE: begin
                case ({funct7_i, funct3_i})
                    {F7_BASE, 3'b000}: op_c_o = OP_ADD;
                    {F7_ALT,  3'b000}: op_c_o = OP_SUB;
                    {F7_BASE, 3'b001}: op_c_o = OP_SLL;
                    {F7_BASE, 3'b010}: op_c_o = OP_SLT;
                    {F7_BASE, 3'b011}: op_c_o = OP_SLTU;
                    {F7_BASE, 3'b100}: op_c_o = OP_XOR;
                    {F7_BASE, 3'b101}: op_c_o = OP_SRL;
                    {F7_ALT,  3'b101}: op_c_o = OP_SRA;
                    {F7_BASE, 3'b110}: op_c_o = OP_OR;
                    {F7_BASE, 3'b111}: op_c_o = OP_AND;
`ifdef ALU_MUL_EN
                    {F7_MULDIV, 3'b000}: op_c_o = OP_MUL;
`endif
                    default: illegal_c_o = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                // funct7 carries immediate bits, so it only qualifies the shift encodings
                case (funct3_i)
                    3'b000: op_c_o = OP_ADD;
                    3'b001: begin
                        op_c_o      = OP_SLL;
                        illegal_c_o = (funct7_i != F7_BASE);
                    end
                    3'b010: op_c_o = OP_SLT;
                    3'b011: op_c_o = OP_SLTU;
                    3'b100: op_c_o = OP_XOR;
                    3'b101: begin
                        if (funct7_i == F7_BASE) begin
                            op_c_o = OP_SRL;
                        end else if (funct7_i == F7_ALT) begin
                            op_c_o = OP_SRA;
                        end else begin
                            illegal_c_o = 1'b1;
                        end
                    end
                    3'b110: op_c_o = OP_OR;
                    default: op_c_o = OP_AND;
                endcase
            end
            default: illegal_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decode + XLEN-wide ALU with iterative shifter and valid/ready handshakes.
// Define ALU_MUL_EN to add an XLEN-iteration shift-add multiplier.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned SHW  = $clog2(XLEN);
    localparam int unsigned CNTW = SHW + 1;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            zero_q, zero_d, illo_q, illo_d;

    logic [OP_W-1:0] dec_op;
    logic            dec_ill;
    logic [XLEN-1:0] alu_res, shifted;
    logic [CNTW-1:0] step;
    logic            accept;

    alu_op_decode u_decode (
        .alu_op_i    (alu_op),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .op_c_o      (dec_op),
        .illegal_c_o (dec_ill)
    );

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = illo_q;

    // Single-cycle ALU on the captured operands
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_SLT:  alu_res = XLEN'($signed(a_q) < $signed(b_q));
            OP_SLTU: alu_res = XLEN'(a_q < b_q);
            default: alu_res = '0;
        endcase
    end

    // One shifter iteration: move acc by min(SHIFT_STEP, remaining)
    always_comb begin
        step    = (cnt_q > CNTW'(SHIFT_STEP)) ? CNTW'(SHIFT_STEP) : cnt_q;
        shifted = acc_q >> step;
        if (op_q == OP_SLL) begin
            shifted = acc_q << step;
        end else if (op_q == OP_SRA) begin
            shifted = XLEN'($signed(acc_q) >>> step);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ill_d   = ill_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        illo_d  = illo_q;
        case (state_q)
            S_EXEC: begin
                if (ill_q) begin
                    res_d   = '0;
                    zero_d  = 1'b1;
                    illo_d  = 1'b1;
                    state_d = S_DONE;
                end else if (is_shift(op_q)) begin
                    acc_d   = a_q;
                    cnt_d   = CNTW'(b_q[SHW-1:0]);
                    state_d = S_ITER;
`ifdef ALU_MUL_EN
                end else if (op_q == OP_MUL) begin
                    acc_d   = '0;
                    cnt_d   = CNTW'(XLEN);
                    state_d = S_ITER;
`endif
                end else begin
                    res_d   = alu_res;
                    zero_d  = (alu_res == '0);
                    illo_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_ITER: begin
`ifdef ALU_MUL_EN
                if (op_q == OP_MUL) begin
                    acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q - CNTW'(1);
                end else begin
                    acc_d = shifted;
                    cnt_d = cnt_q - step;
                end
`else
                acc_d = shifted;
                cnt_d = cnt_q - step;
`endif
                if (cnt_d == '0) begin
                    res_d   = acc_d;
                    zero_d  = (acc_d == '0);
                    illo_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        // Accept overrides the hand-off transition so DONE can go straight to EXEC
        if (accept) begin
            state_d = S_EXEC;
            op_d    = dec_op;
            ill_d   = dec_ill;
            a_d     = op_a;
            b_d     = op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            ill_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            illo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            illo_q  <= illo_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (XLEN=32, SHIFT_STEP=1); honours ALU_MUL_EN.
module tb_alu_exec_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycles from the accept cycle (0) until out_valid is seen; -1 on timeout
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, output int lat);
        drive(op, f3, f7, a, b);
        wait_valid(lat);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if ({zero, illegal, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {zero, illegal, busy}); end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        drive(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd31);
        repeat (5) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midshift_busy: got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midshift_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midshift_in_ready: got %b want 1", in_ready); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL midshift_result: got %h want 0", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midshift_busy_after: got %b want 0", busy); end
        rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL midshift_aborted: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_add_sub();
        int lat;
        run_op(2'b10, 3'b000, 7'h00, 32'hFFFF_FFFF, 32'h1, lat);
        total++; if (result !== 32'h0) begin bad++; $display("FAIL add_wrap_result: got %h want 0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL add_wrap_zero: got %b want 1", zero); end
        total++; if (lat != 2) begin bad++; $display("FAIL add_latency: got %0d want 2", lat); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL add_illegal: got %b want 0", illegal); end
        take();
        run_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, lat);
        total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_result: got %h want fffffffe", result); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL sub_zero: got %b want 0", zero); end
        take();
        run_op(2'b00, 3'b011, 7'h7F, 32'h0000_1000, 32'h24, lat);
        total++; if (result !== 32'h0000_1024) begin bad++; $display("FAIL ldst_add: got %h want 00001024", result); end
        take();
        run_op(2'b11, 3'b000, 7'h7F, 32'd10, 32'hFFFF_FFFF, lat);
        total++; if (result !== 32'd9) begin bad++; $display("FAIL addi_neg: got %h want 9", result); end
        take();
    endtask

    task automatic test_logic();
        int lat;
        logic [2:0] f3;
        logic [XLEN-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin f3 = 3'b100; exp = 32'hFF00_444C; end
                1:       begin f3 = 3'b110; exp = 32'hFFF0_567C; end
                default: begin f3 = 3'b111; exp = 32'h00F0_1230; end
            endcase
            run_op(2'b10, f3, 7'h00, 32'hF0F0_1234, 32'h0FF0_5678, lat);
            total++; if (result !== exp) begin bad++; $display("FAIL logic_f3_%0d: got %h want %h", f3, result, exp); end
            take();
        end
    endtask

    task automatic test_branch();
        int lat;
        run_op(2'b01, 3'b100, 7'h00, 32'h8000_0000, 32'h1, lat);
        total++; if (result !== 32'h1) begin bad++; $display("FAIL branch_slt: got %h want 1", result); end
        take();
        run_op(2'b01, 3'b110, 7'h00, 32'h8000_0000, 32'h1, lat);
        total++; if ({result, zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL branch_sltu: got %h/%b want 0/1", result, zero); end
        take();
        run_op(2'b01, 3'b000, 7'h00, 32'd9, 32'd9, lat);
        total++; if ({result, zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL branch_beq: got %h/%b want 0/1", result, zero); end
        take();
        run_op(2'b01, 3'b010, 7'h00, 32'd3, 32'd1, lat);
        total++; if ({illegal, result} !== {1'b1, 32'h0}) begin bad++; $display("FAIL branch_illegal: got %b/%h want 1/0", illegal, result); end
        take();
        run_op(2'b11, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'h1, lat);
        total++; if (result !== 32'h1) begin bad++; $display("FAIL slti_neg: got %h want 1", result); end
        take();
        run_op(2'b11, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'h1, lat);
        total++; if (result !== 32'h0) begin bad++; $display("FAIL sltiu_big: got %h want 0", result); end
        take();
    endtask

    task automatic test_shift();
        int lat;
        run_op(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd31, lat);
        total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL srai31_result: got %h want ffffffff", result); end
        total++; if (lat != 33) begin bad++; $display("FAIL srai31_latency: got %0d want 33", lat); end
        take();
        run_op(2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'd0, lat);
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL srai0_result: got %h want 80000000", result); end
        total++; if (lat != 3) begin bad++; $display("FAIL srai0_latency: got %0d want 3", lat); end
        take();
        run_op(2'b10, 3'b001, 7'h00, 32'h1, 32'd4, lat);
        total++; if ({result, lat[7:0]} !== {32'h10, 8'd6}) begin bad++; $display("FAIL sll4: got %h lat %0d want 10 lat 6", result, lat); end
        take();
        run_op(2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'h24, lat);
        total++; if (result !== 32'h0800_0000) begin bad++; $display("FAIL srl_shamt_mask: got %h want 08000000", result); end
        take();
        run_op(2'b11, 3'b001, 7'h01, 32'h1, 32'd4, lat);
        total++; if ({illegal, result} !== {1'b1, 32'h0}) begin bad++; $display("FAIL slli_bad_f7: got %b/%h want 1/0", illegal, result); end
        take();
        run_op(2'b11, 3'b101, 7'h10, 32'h1, 32'd4, lat);
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL srxi_bad_f7: got %b want 1", illegal); end
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(2'b10, 3'b000, 7'h00, 32'd3, 32'd4, lat);
        for (int i = 0; i < 5; i++) begin
            total++; if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd7}) begin bad++; $display("FAIL stall_cycle_%0d: got v%b r%b %h want v1 r0 7", i, out_valid, in_ready, result); end
            @(posedge clk); #1;
        end
        alu_op = 2'b10; funct3 = 3'b000; funct7 = 7'h00; op_a = 32'd1; op_b = 32'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL handoff_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if ({out_valid, busy} !== 2'b01) begin bad++; $display("FAIL handoff_exec: got v%b b%b want v0 b1", out_valid, busy); end
        wait_valid(lat);
        total++; if ({result, lat[7:0]} !== {32'd2, 8'd2}) begin bad++; $display("FAIL handoff_next: got %h lat %0d want 2 lat 2", result, lat); end
        take();
        total++; if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL handoff_idle: got v%b b%b want v0 b0", out_valid, busy); end
    endtask

    task automatic test_mul_encoding();
        int lat;
        run_op(2'b10, 3'b000, 7'h01, 32'd7, 32'd6, lat);
`ifdef ALU_MUL_EN
        total++; if ({illegal, result} !== {1'b0, 32'd42}) begin bad++; $display("FAIL mul_result: got %b/%h want 0/2a", illegal, result); end
        total++; if (lat != XLEN + 2) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat, XLEN + 2); end
`else
        total++; if ({illegal, zero, result} !== {2'b11, 32'h0}) begin bad++; $display("FAIL mul_illegal: got %b%b/%h want 11/0", illegal, zero, result); end
        total++; if (lat != 2) begin bad++; $display("FAIL mul_illegal_latency: got %0d want 2", lat); end
`endif
        take();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_add_sub();
        test_logic();
        test_branch();
        test_shift();
        test_backpressure();
        test_mul_encoding();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
